// File: rtl/apb_timer_slave_if.sv
// rtl/apb_timer_slave_if.sv - APB bus bundle between the AHB-to-APB bridge and the timer slave
interface apb_timer_slave_if;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Psel,
        output Penable,
        output Pwrite,
        output Paddr,
        output Pwdata,
        input  Prdata
    );

    modport slave (
        input  Psel,
        input  Penable,
        input  Pwrite,
        input  Paddr,
        input  Pwdata,
        output Prdata
    );
endinterface

// File: rtl/apb_timer_slave.sv
// rtl/apb_timer_slave.sv - zero-wait APB down-counting timer with auto-reload, sticky expiry, irq, scratch (optional prescaler: APB_TIMER_PRESCALE_EN)
module apb_timer_slave #(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter logic [31:0] RESET_LOAD = 32'h0
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    apb_timer_slave_if.slave apb,
    output logic             Irq
);
    localparam logic [2:0]           A_CTRL    = 3'd0;
    localparam logic [2:0]           A_LOAD    = 3'd1;
    localparam logic [2:0]           A_VALUE   = 3'd2;
    localparam logic [2:0]           A_STATUS  = 3'd3;
    localparam logic [2:0]           A_SCRATCH = 3'd4;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 en_q;
    logic                 auto_reload_q;
    logic                 irq_en_q;
    logic                 exp_q;
    logic [CNT_WIDTH-1:0] load_q;
    logic [CNT_WIDTH-1:0] value_q;
    logic [31:0]          scratch_q;
    logic [7:0]           presc_field;
    logic                 tick;

    logic [2:0] addr;
    logic       wr_access;
    logic       rd_setup;
    logic       wr_ctrl;
    logic       wr_load;
    logic       wr_status;
    logic       wr_scratch;
    logic       start;
    logic       expire;
    logic       unused_bus;

    assign addr       = apb.Paddr[4:2];
    assign wr_access  = apb.Psel & apb.Penable & apb.Pwrite;
    assign rd_setup   = apb.Psel & ~apb.Penable & ~apb.Pwrite;
    assign wr_ctrl    = wr_access & (addr == A_CTRL);
    assign wr_load    = wr_access & (addr == A_LOAD);
    assign wr_status  = wr_access & (addr == A_STATUS);
    assign wr_scratch = wr_access & (addr == A_SCRATCH);

    // Only a 0->1 EN transition restarts the count; rewriting EN=1 leaves it running.
    assign start  = wr_ctrl & apb.Pwdata[0] & ~en_q;
    assign expire = tick & (value_q == '0);

    // Address bits outside [4:2] and data bits beyond the register fields are don't-care.
    assign unused_bus = ^{apb.Paddr, apb.Pwdata};

`ifdef APB_TIMER_PRESCALE_EN
    logic [7:0] presc_q;
    logic [7:0] presc_cnt_q;

    assign tick        = en_q & (presc_cnt_q == presc_q);
    assign presc_field = presc_q;

    // Prescale divider field of CTRL.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            presc_q <= '0;
        end else if (wr_ctrl) begin
            presc_q <= apb.Pwdata[15:8];
        end
    end

    // Prescale count runs 0..PRESC while enabled, restarts on start and after each tick.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            presc_cnt_q <= '0;
        end else if (start || !en_q || tick) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_q + 8'd1;
        end
    end
`else
    assign tick        = en_q;
    assign presc_field = 8'h00;
`endif

    // CTRL bits; a bus write takes priority over the one-shot hardware EN clear.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
        end else if (wr_ctrl) begin
            en_q          <= apb.Pwdata[0];
            auto_reload_q <= apb.Pwdata[1];
            irq_en_q      <= apb.Pwdata[2];
        end else if (expire && !auto_reload_q) begin
            en_q <= 1'b0;
        end
    end

    // LOAD register; truncated to the counter width.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            load_q <= RESET_LOAD[CNT_WIDTH-1:0];
        end else if (wr_load) begin
            load_q <= apb.Pwdata[CNT_WIDTH-1:0];
        end
    end

    // Down counter; reload reads the pre-write LOAD when both happen in one cycle.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            value_q <= '0;
        end else if (start) begin
            value_q <= load_q;
        end else if (tick) begin
            if (value_q != '0) begin
                value_q <= value_q - CNT_ONE;
            end else if (auto_reload_q) begin
                value_q <= load_q;
            end
        end
    end

    // Sticky expiry flag; a hardware set beats a simultaneous write-1-to-clear.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            exp_q <= 1'b0;
        end else if (expire) begin
            exp_q <= 1'b1;
        end else if (wr_status && apb.Pwdata[0]) begin
            exp_q <= 1'b0;
        end
    end

    // Scratch register for software use.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            scratch_q <= '0;
        end else if (wr_scratch) begin
            scratch_q <= apb.Pwdata;
        end
    end

    logic [31:0] load_ext;
    logic [31:0] value_ext;
    logic [31:0] rd_data;

    // Read mux; counter registers are zero-extended, unused offsets read zero.
    always_comb begin
        load_ext                  = '0;
        load_ext[CNT_WIDTH-1:0]   = load_q;
        value_ext                 = '0;
        value_ext[CNT_WIDTH-1:0]  = value_q;
        rd_data                   = '0;
        case (addr)
            A_CTRL:    rd_data = {16'h0000, presc_field, 5'b00000, irq_en_q, auto_reload_q, en_q};
            A_LOAD:    rd_data = load_ext;
            A_VALUE:   rd_data = value_ext;
            A_STATUS:  rd_data = {31'h0, exp_q};
            A_SCRATCH: rd_data = scratch_q;
            default:   rd_data = '0;
        endcase
    end

    // Read data is captured in the setup phase and held until the next read setup.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            apb.Prdata <= '0;
        end else if (rd_setup) begin
            apb.Prdata <= rd_data;
        end
    end

    assign Irq = exp_q & irq_en_q;
endmodule

// File: tb/tb_apb_timer_slave.sv
// tb/tb_apb_timer_slave.sv - scoreboard bench for apb_timer_slave against a closed-form timer model
module tb_apb_timer_slave;
    localparam int          CW    = 16;
    localparam int          CMASK = 32'h0000_FFFF;
    localparam logic [31:0] RLOAD = 32'h0000_0005;
`ifdef APB_TIMER_PRESCALE_EN
    localparam bit PRESC_EN = 1'b1;
`else
    localparam bit PRESC_EN = 1'b0;
`endif

    logic Hclk;
    logic Hresetn;
    logic Irq;

    apb_timer_slave_if bus ();

    apb_timer_slave #(.CNT_WIDTH(CW), .RESET_LOAD(RLOAD)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .apb     (bus),
        .Irq     (Irq)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [31:0] sb_q[$];
    int          sb_addr_q[$];

    // Model: registers plus one "run" described by its start edge and parameters.
    int          m_load;
    logic [31:0] m_scratch;
    bit          m_ar, m_ie;
    int          m_presc_w;
    bit          m_started;
    int          m_start, m_stop, m_clear, m_prev_set;
    int          m_rl, m_rp;
    bit          m_rar;

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    always @(posedge Hclk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int k_at(input int c);
        int e;
        e = c;
        if (m_stop >= 0 && m_stop < c) e = m_stop;
        return e - m_start;
    endfunction

    function automatic int ticks_at(input int c);
        return k_at(c) / (m_rp + 1);
    endfunction

    function automatic int value_at(input int c);
        int n;
        if (!m_started) return 0;
        n = ticks_at(c);
        if (m_rar) return m_rl - (n % (m_rl + 1));
        return (n <= m_rl) ? m_rl - n : 0;
    endfunction

    function automatic bit en_at(input int c);
        if (!m_started) return 1'b0;
        if (m_stop >= 0 && c >= m_stop) return 1'b0;
        return m_rar || (ticks_at(c) < m_rl + 1);
    endfunction

    function automatic int last_exp(input int c);
        int m;
        if (!m_started) return -1;
        m = ticks_at(c) / (m_rl + 1);
        if (!m_rar && m > 1) m = 1;
        return (m >= 1) ? m_start + m * (m_rl + 1) * (m_rp + 1) : -1;
    endfunction

    function automatic bit exp_at(input int c);
        int e;
        e = last_exp(c);
        if (m_prev_set > e) e = m_prev_set;
        return (e >= 0) && (e >= m_clear);
    endfunction

    function automatic logic [31:0] rd_model(input int a, input int c);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            0: v = (PRESC_EN ? 32'(m_presc_w << 8) : 32'h0) | 32'({m_ie, m_ar, en_at(c)});
            1: v = 32'(m_load);
            2: v = 32'(value_at(c));
            3: v = 32'(exp_at(c));
            4: v = m_scratch;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic reset_model();
        m_load     = int'(RLOAD) & CMASK;
        m_scratch  = 32'h0;
        m_ar       = 1'b0;
        m_ie       = 1'b0;
        m_presc_w  = 0;
        m_started  = 1'b0;
        m_start    = 0;
        m_stop     = -1;
        m_clear    = -1;
        m_prev_set = -1;
        m_rl       = 0;
        m_rp       = 0;
        m_rar      = 1'b0;
    endtask

    task automatic model_write(input int a, input logic [31:0] d, input int commit);
        int le;
        case (a)
            0: begin
                if (d[0] && !en_at(commit - 1)) begin
                    le = last_exp(commit);
                    if (le > m_prev_set) m_prev_set = le;
                    m_started = 1'b1;
                    m_start   = commit;
                    m_stop    = -1;
                    m_rl      = m_load;
                    m_rar     = d[1];
                    m_rp      = PRESC_EN ? int'(d[15:8]) : 0;
                end else if (!d[0] && m_started && m_stop < 0) begin
                    m_stop = commit;
                end
                m_ar      = d[1];
                m_ie      = d[2];
                m_presc_w = int'(d[15:8]);
            end
            1: m_load = int'(d) & CMASK;
            3: if (d[0]) m_clear = commit;
            4: m_scratch = d;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] addr_bits(input int a);
        logic [31:0] r;
        r      = $urandom;
        r[4:2] = a[2:0];
        return r;
    endfunction

    task automatic bus_idle();
        bus.Psel    = 1'b0;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
    endtask

    // Called at a falling edge; returns at a falling edge with the bus idle.
    task automatic apb_write(input int a, input logic [31:0] d);
        int commit;
        bus.Psel    = 1'b1;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = addr_bits(a);
        bus.Pwdata  = d;
        @(negedge Hclk);
        bus.Penable = 1'b1;
        commit      = cyc + 1;
        @(posedge Hclk);
        model_write(a, d, commit);
        @(negedge Hclk);
        bus_idle();
    endtask

    task automatic apb_read(input int a);
        sb_q.push_back(rd_model(a, cyc));
        sb_addr_q.push_back(a);
        bus.Psel    = 1'b1;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = addr_bits(a);
        @(negedge Hclk);
        bus.Penable = 1'b1;
        @(negedge Hclk);
        bus_idle();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Hclk);
    endtask

    // Monitor: checks Irq every cycle and pops the scoreboard when read data is captured.
    always @(posedge Hclk) begin
        logic [31:0] e;
        int          a;
        #2;
        if (mon_en) check("irq", {31'h0, Irq}, {31'h0, exp_at(cyc) && m_ie});
        if (Hresetn && bus.Psel && !bus.Penable && !bus.Pwrite) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_read", 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                a = sb_addr_q.pop_front();
                check($sformatf("rd_off%0d", a), bus.Prdata, e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int          found;
        int          l, p, a;
        bit          ar, ie;
        logic [31:0] cv;

        bus_idle();
        bus.Paddr  = 32'h0;
        bus.Pwdata = 32'h0;
        Hresetn    = 1'b0;
        reset_model();
        idle(3);
        Hresetn = 1'b1;
        check("rst_irq", {31'h0, Irq}, 32'h0);
        check("rst_prdata", bus.Prdata, 32'h0);
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) apb_read(i);

        // Scratch write/read; setup-only and unselected writes must not land.
        apb_write(4, 32'hDEADBEEF);
        apb_read(4);
        bus.Psel = 1'b1; bus.Pwrite = 1'b1; bus.Penable = 1'b0;
        bus.Paddr = addr_bits(4); bus.Pwdata = 32'h0BADF00D;
        @(negedge Hclk);
        bus_idle();
        bus.Psel = 1'b0; bus.Pwrite = 1'b1; bus.Penable = 1'b1;
        bus.Paddr = addr_bits(4); bus.Pwdata = 32'h0BADF00D;
        @(negedge Hclk);
        bus_idle();
        apb_read(4);

        // LOAD truncation, then one-shot run.
        apb_write(1, 32'hABCD_0003);
        apb_read(1);
        apb_write(0, 32'h1);
        repeat (4) apb_read(2);
        apb_read(3);
        apb_read(0);
        apb_read(2);

        // Auto-reload with interrupt, W1C off and on the expiry edge.
        apb_write(3, 32'h1);
        apb_write(1, 32'h2);
        apb_write(0, 32'h7);
        idle(9);
        apb_write(3, 32'h1);
        idle(4);
        while (((cyc + 2 - m_start) % 3) != 0) @(negedge Hclk);
        apb_write(3, 32'h1);
        check("w1c_set_wins", {31'h0, Irq}, 32'h1);
        apb_read(3);
        apb_write(0, 32'h7);
        idle(4);
        apb_read(2);

        // Prescaler.
        apb_write(0, 32'h0);
        apb_write(3, 32'h1);
        apb_write(1, 32'h1);
        apb_write(0, 32'h0301);
        apb_read(0);
        repeat (5) apb_read(3);
        apb_write(0, 32'h0);
        apb_write(3, 32'h1);
        apb_write(0, 32'h0305);
        found = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge Hclk);
            #2;
            if (Irq) begin
                found = cyc - m_start;
                break;
            end
        end
        check("presc_expiry_cycle", 32'(found), PRESC_EN ? 32'd8 : 32'd2);
        @(negedge Hclk);

        // Randomised runs.
        for (int r = 0; r < 8; r++) begin
            l  = $urandom_range(0, 5);
            p  = $urandom_range(0, 3);
            ar = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            apb_write(0, 32'h0);
            apb_write(1, ($urandom & 32'hFFFF_0000) | 32'(l));
            cv = 32'(p << 8) | 32'({ie, ar, 1'b1});
            apb_write(0, cv);
            for (int i = 0; i < 14; i++) begin
                case ($urandom_range(0, 5))
                    0, 1: apb_read($urandom_range(0, 7));
                    2: apb_write(3, $urandom);
                    3: apb_write(4, $urandom);
                    4: begin
                        a = $urandom_range(0, 3);
                        apb_write((a == 0) ? 2 : a + 4, $urandom);
                    end
                    default: begin
                        if (ar) apb_write(0, cv);
                        else apb_write(1, $urandom & 32'h7);
                    end
                endcase
            end
            apb_read(2);
            apb_read(0);
        end

        // Asynchronous reset mid-count with Irq high.
        apb_write(0, 32'h0);
        apb_write(3, 32'h1);
        apb_write(1, 32'h2);
        apb_write(4, 32'h1234_5678);
        apb_write(0, 32'h7);
        apb_read(4);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Hclk);
            #2;
            if (Irq) begin
                found = 1;
                break;
            end
        end
        check("pre_reset_irq_high", 32'(found), 32'h1);
        mon_en = 1'b0;
        #1;
        Hresetn = 1'b0;
        #1;
        check("async_rst_irq", {31'h0, Irq}, 32'h0);
        check("async_rst_prdata", bus.Prdata, 32'h0);
        reset_model();
        idle(2);
        Hresetn = 1'b1;
        mon_en  = 1'b1;
        apb_read(0);
        apb_read(2);
        apb_read(4);
        apb_read(3);

        idle(3);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB peripheral on the APB side of the AHB-to-APB bridge.
- Consumes one bridge select line plus Penable, Pwrite, Paddr and Pwdata, and returns Prdata to the bridge.
- Contains a down-counting timer with auto-reload, a sticky expiry flag, a level interrupt and a scratch register.
- Zero-wait-state APB (no PREADY/PSLVERR), matching what the bridge supports.

Parameters:
- CNT_WIDTH, 32: width of the LOAD and VALUE registers, 1..32; zero-extended on read, truncated on write.
- RESET_LOAD, 0: reset value of LOAD.

Ports:
- Hclk  in  1  system clock; all state on rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- Psel  in  1  this slave's bit of the bridge Pselx.
- Penable  in  1  APB access phase.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address; only Paddr[4:2] decoded.
- Pwdata  in  32  write data.
- Prdata  out  32  read data, registered.
- Irq  out  1  level interrupt, STATUS.EXP & CTRL.IRQ_EN.

Behaviour:
- Register map (Paddr[4:2]):
  - 0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [15:8] PRESC.
  - 1 LOAD: RW.
  - 2 VALUE: RO.
  - 3 STATUS: [0] EXP, write-1-to-clear.
  - 4 SCRATCH: RW 32b.
  - 5-7: read 0, writes ignored.
  - Unused bits read 0.
- Reset values: CTRL=0, LOAD=RESET_LOAD, VALUE=0, STATUS=0, SCRATCH=0, prescale count=0, Prdata=0, Irq=0.
- Write commit: registers update on the edge ending the access phase (Psel & Penable & Pwrite). Setup-phase writes have no effect.
- Read capture:
  - On the setup-phase edge (Psel & ~Penable & ~Pwrite), Prdata <= addressed register.
  - Prdata is therefore valid throughout the access phase and held until the next read setup.
  - VALUE reads return the counter as sampled at setup.
- Start: a CTRL write changing EN 0->1 loads VALUE <= LOAD and clears the prescale count. The first decrement occurs on the first tick after that.
- Tick: when EN=1, the prescale count runs 0..PRESC. A tick fires on the cycle it equals PRESC, then the count returns to 0. PRESC=0 gives a tick every cycle. EN=0 holds the prescale count at 0.
- On tick:
  - VALUE!=0: VALUE <= VALUE-1.
  - VALUE==0: EXP <= 1. If AUTO_RELOAD, VALUE <= LOAD. Otherwise EN <= 0 and VALUE stays 0.
  - Period = (LOAD+1)*(PRESC+1) cycles.
- LOAD write does not change VALUE; it takes effect at the next start or reload.
- Writing EN=0 freezes VALUE; VALUE is readable.
- Writing EN=1 while EN is already 1 does not reload.
- Simultaneous events:
  - Expiry set and W1C of EXP in the same cycle: EXP ends 1 (set wins).
  - CTRL write and hardware EN clear in the same cycle: the APB write wins.
  - LOAD write and auto-reload in the same cycle: the reload uses the old LOAD.
- Reset mid-operation: asynchronously returns all state to reset values. Irq deasserts immediately. Any in-flight APB transfer is discarded.
- Psel=0: no register changes from the bus; Prdata holds.

Optional Feature:
- Macro APB_TIMER_PRESCALE_EN.
- Defined: PRESC field implemented as above.
- Undefined: no prescale counter; a tick fires every cycle while EN=1; CTRL[15:8] reads 0 and writes to it are ignored.

Test Plan:
- Reset then read all 8 offsets: all return 0 except LOAD = RESET_LOAD. Irq=0.
- Write SCRATCH=0xDEADBEEF then read it back: Prdata=0xDEADBEEF in the access phase. A write with Penable never asserted leaves SCRATCH unchanged.
- LOAD=3, CTRL=0x1 (one-shot, PRESC=0):
  - VALUE reads 3,2,1,0 on consecutive ticks.
  - EXP=1 on the 4th tick after start (cycle 4), then EN reads 0 and VALUE stays 0.
  - Irq stays 0 because IRQ_EN=0.
- LOAD=2, CTRL=0x7:
  - EXP and Irq assert every 3 cycles.
  - Write STATUS=1 → Irq drops next cycle, then re-asserts at the next expiry.
  - A W1C landing in the expiry cycle leaves EXP=1.
- With APB_TIMER_PRESCALE_EN: LOAD=1, CTRL=0x0301 → expiry at cycle 8 after start. Without the macro: CTRL reads 0x0001 and expiry occurs at cycle 2.
- Assert Hresetn low mid-count with Irq high: Irq=0 and Prdata=0 immediately, before any clock edge. After release, CTRL=0 and VALUE=0.
